sdram_init_seq: RTL and testbench
=================================

# sdram_init_seq

Power-up initialization sequencer for the SDR SDRAM. It runs in the system `clk` domain produced by the clock/PLL stage, directly downstream of that stage's clock and reset outputs. After reset it waits the power-up interval, raises CKE, then issues PRECHARGE ALL, N × AUTO REFRESH and LOAD MODE REGISTER with the JEDEC spacings. When the sequence completes it asserts `done`, and the SDRAM controller takes over the command pins.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 100_000_000 — frequency of `clk`.
- `T_POWERUP_US`, 200 — power-up NOP interval in µs; `POWERUP_CYCLES = CLK_FREQ_HZ / 1_000_000 * T_POWERUP_US`, which must be ≥ 1.
- `T_RP`, 2 — cycles from PRECHARGE to the next command, ≥ 1.
- `T_RFC`, 7 — cycles from each REFRESH to the next command, ≥ 1.
- `T_MRD`, 2 — cycles from MRS to `done`, ≥ 1.
- `REFRESH_COUNT`, 8 — number of AUTO REFRESH commands, ≥ 1.
- `MODE_REG`, 13'h030 — value driven on `a` during MRS (CL3, burst 1, sequential).

Ports:
- `clk` in 1 — system clock; all logic sits on its rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `cke` out 1 — SDRAM clock enable.
- `cmd` out 4 — {cs_n, ras_n, cas_n, we_n}, encoded with `sdram_cmd_e`.
- `ba` out 2 — bank address.
- `a` out 13 — address bus.
- `done` out 1 — initialization complete; sticky until reset.

## Operation
- States, all in `sdram_init_state_e`: WAIT_POWERUP → CKE_UP → PRECHARGE → WAIT_RP → REFRESH → WAIT_RFC → (REFRESH again, or MRS) → WAIT_MRD → DONE.
- **WAIT_POWERUP:** a down-counter is loaded with `POWERUP_CYCLES-1` and counts down; the state exits when the counter reaches 0.
- **CKE_UP:** lasts one cycle; `cke`←1 and `cmd`=NOP.
- **PRECHARGE:** lasts one cycle; `cmd`=PRE, `a[10]`=1, all other `a` bits 0, `ba`=0.
- **REFRESH:** lasts one cycle; `cmd`=REF. The refresh counter increments and the state returns to REFRESH until `REFRESH_COUNT` refreshes have been issued.
- **MRS:** lasts one cycle; `cmd`=MRS, `ba`=0, `a`=`MODE_REG`.
- **Command spacing:** the WAIT_* states issue NOP. The next command appears exactly T_x cycles after the previous command. With T_x = 1, commands are back-to-back and the WAIT state is skipped.
- **DONE:** `done`=1, `cke`=1, `cmd`=NOP. The block stays here until reset.
- **Pin ownership:** after `done`, these outputs are ignored. The controller muxes the pins on `done`.
- **Reset mid-sequence:** every output returns to its reset value immediately, because the reset is asynchronous. The full power-up wait is reloaded, and no partial sequence is resumed.
- **Counter widths:** the power-up counter is `$clog2(POWERUP_CYCLES)` bits (minimum 1). The refresh counter is `$clog2(REFRESH_COUNT+1)` bits. There is no wrap-around: counters saturate at 0 and the FSM leaves the state on 0.

## Timing
- Reset values: `cke`=0, `cmd`=NOP (4'b0111), `ba`=0, `a`=0, `done`=0, state=WAIT_POWERUP, counters loaded.
- All outputs are registered. "Edge k" is the k-th rising edge after `reset_n` deasserts, counting from 0; outputs change just after that edge.
- CKE_UP occurs at edge `POWERUP_CYCLES`. PRECHARGE occurs at edge `POWERUP_CYCLES+1`.
- The first REFRESH occurs at PRE edge + T_RP. Each subsequent command occurs at the previous REFRESH edge + T_RFC.
- MRS occurs at the last REFRESH edge + T_RFC. `done` rises at MRS edge + T_MRD.
- Total latency from reset release to `done` = POWERUP_CYCLES + 1 + T_RP + REFRESH_COUNT·T_RFC + T_MRD.
- `reset_n` deassertion is synchronized by the upstream stage; this block does not add a synchronizer.

## Structure
- Shared package `sdram_pkg` holds:
  - `sdram_cmd_e` (DESELECT=4'b1111, NOP=4'b0111, PRE=4'b0010, REF=4'b0001, MRS=4'b0000), shared with the SDRAM controller;
  - `sdram_init_state_e`;
  - the SDRAM address and bank widths.
- One sub-module, `sdram_delay_counter`: a parameterized loadable down-counter with a `zero` flag. It is used for the power-up wait and for the T_RP/T_RFC/T_MRD spacing.

## Test plan
Unless stated otherwise, the bench uses CLK_FREQ_HZ=1_000_000, T_POWERUP_US=10, T_RP=2, T_RFC=7, REFRESH_COUNT=2, T_MRD=2.
- **Nominal sequence:** release reset → `cke` rises at edge 10, PRE with `a[10]`=1 at edge 11, REF at edges 13 and 20, MRS with `a`=13'h030 and `ba`=0 at edge 27, `done`=1 at edge 29. NOP appears on all other edges.
- **Reset values:** hold `reset_n`=0 for 5 cycles → `cke`=0, `cmd`=4'b0111, `ba`=0, `a`=0, `done`=0 throughout.
- **Reset mid-sequence:** assert `reset_n`=0 asynchronously between edges 15 and 16, then release → outputs reset immediately without waiting for a clock. The repeated sequence again shows PRE at edge 11 relative to the new release.
- **Minimum spacing:** set T_RP=T_RFC=T_MRD=1, REFRESH_COUNT=1 → PRE at edge 11, REF at 12, MRS at 13, `done` at 14.
- **Sticky done:** run 100 cycles past `done` → `done` stays 1, `cke` stays 1, `cmd` stays NOP, and no further commands are issued.
- **Full-size parameters:** use defaults (100 MHz, 200 µs) → `cke` rises at edge 20000 and `done` rises at edge 20000+1+2+56+2=20061.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init-sequencer states and bus widths.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 13;
  localparam int SDRAM_BA_W   = 2;

  // {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    DESELECT = 4'b1111,
    NOP      = 4'b0111,
    PRE      = 4'b0010,
    REF      = 4'b0001,
    MRS      = 4'b0000
  } sdram_cmd_e;

  typedef enum logic [3:0] {
    ST_WAIT_POWERUP,
    ST_CKE_UP,
    ST_PRECHARGE,
    ST_WAIT_RP,
    ST_REFRESH,
    ST_WAIT_RFC,
    ST_MRS,
    ST_WAIT_MRD,
    ST_DONE
  } sdram_init_state_e;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/sdram_delay_counter.sv
// Loadable down-counter that saturates at zero; used for the power-up wait and command spacing.
module sdram_delay_counter #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= RESET_VALUE;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDR SDRAM power-up sequencer: power-up wait, CKE, PRECHARGE ALL, N x AUTO REFRESH, MRS, done.
module sdram_init_seq
  import sdram_pkg::*;
#(
  parameter int                       CLK_FREQ_HZ   = 100_000_000,
  parameter int                       T_POWERUP_US  = 200,
  parameter int                       T_RP          = 2,
  parameter int                       T_RFC         = 7,
  parameter int                       T_MRD         = 2,
  parameter int                       REFRESH_COUNT = 8,
  parameter logic [SDRAM_ADDR_W-1:0]  MODE_REG      = 13'h030
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    cke,
  output logic [3:0]              cmd,
  output logic [SDRAM_BA_W-1:0]   ba,
  output logic [SDRAM_ADDR_W-1:0] a,
  output logic                    done
);

  localparam int POWERUP_CYCLES = CLK_FREQ_HZ / 1_000_000 * T_POWERUP_US;
  localparam int PU_W  = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam int T_MAX = max_int(T_RP, max_int(T_RFC, T_MRD));
  localparam int GAP_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int CNT_W = max_int(PU_W, GAP_W);
  localparam int REF_W = $clog2(REFRESH_COUNT + 1);
  localparam logic [CNT_W-1:0] PU_LOAD = CNT_W'(POWERUP_CYCLES - 1);

  // A WAIT state lasts T-1 cycles, so the spacing counter is loaded with T-2.
  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'((T_RP  > 1) ? T_RP  - 2 : 0);
  localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [CNT_W-1:0] MRD_LOAD = CNT_W'((T_MRD > 1) ? T_MRD - 2 : 0);

  sdram_init_state_e state_reg, state_next;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_value;
  logic              cnt_zero;
  logic [REF_W-1:0]  ref_cnt_reg;
  logic              ref_inc;
  logic              cke_next, done_next;
  sdram_cmd_e        cmd_next;
  logic [SDRAM_BA_W-1:0]   ba_next;
  logic [SDRAM_ADDR_W-1:0] a_next;

  sdram_delay_counter #(
    .WIDTH       (CNT_W),
    .RESET_VALUE (PU_LOAD)
  ) u_delay (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (cnt_load),
    .load_value (cnt_value),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_WAIT_POWERUP;
      ref_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (ref_inc && ref_cnt_reg != REF_W'(REFRESH_COUNT)) begin
        ref_cnt_reg <= ref_cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_value  = '0;
    ref_inc    = 1'b0;
    case (state_reg)
      ST_WAIT_POWERUP: if (cnt_zero) state_next = ST_CKE_UP;
      ST_CKE_UP:       state_next = ST_PRECHARGE;
      ST_PRECHARGE: begin
        if (T_RP > 1) begin
          state_next = ST_WAIT_RP;
          cnt_load   = 1'b1;
          cnt_value  = RP_LOAD;
        end else begin
          state_next = ST_REFRESH;
        end
      end
      ST_WAIT_RP:      if (cnt_zero) state_next = ST_REFRESH;
      ST_REFRESH: begin
        ref_inc = 1'b1;
        if (T_RFC > 1) begin
          state_next = ST_WAIT_RFC;
          cnt_load   = 1'b1;
          cnt_value  = RFC_LOAD;
        end else if (ref_cnt_reg == REF_W'(REFRESH_COUNT - 1)) begin
          state_next = ST_MRS;
        end else begin
          state_next = ST_REFRESH;
        end
      end
      ST_WAIT_RFC: begin
        // ref_cnt_reg already counts the refresh that opened this gap.
        if (cnt_zero) begin
          state_next = (ref_cnt_reg == REF_W'(REFRESH_COUNT)) ? ST_MRS : ST_REFRESH;
        end
      end
      ST_MRS: begin
        if (T_MRD > 1) begin
          state_next = ST_WAIT_MRD;
          cnt_load   = 1'b1;
          cnt_value  = MRD_LOAD;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_WAIT_MRD:     if (cnt_zero) state_next = ST_DONE;
      ST_DONE:         state_next = ST_DONE;
      default:         state_next = ST_WAIT_POWERUP;
    endcase
  end

  // Pin values are decoded from the current state and registered, giving one cycle of latency.
  always_comb begin
    cke_next  = (state_reg != ST_WAIT_POWERUP);
    done_next = (state_reg == ST_DONE);
    cmd_next  = NOP;
    ba_next   = '0;
    a_next    = '0;
    case (state_reg)
      ST_PRECHARGE: begin
        cmd_next   = PRE;
        a_next[10] = 1'b1;
      end
      ST_REFRESH:   cmd_next = REF;
      ST_MRS: begin
        cmd_next = MRS;
        a_next   = MODE_REG;
      end
      default:      cmd_next = NOP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cke  <= 1'b0;
      cmd  <= NOP;
      ba   <= '0;
      a    <= '0;
      done <= 1'b0;
    end else begin
      cke  <= cke_next;
      cmd  <= cmd_next;
      ba   <= ba_next;
      a    <= a_next;
      done <= done_next;
    end
  end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: nominal, minimum-spacing and full-size instances against a schedule model.
module tb_sdram_init_seq;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  typedef struct packed {
    logic        cke;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        done;
  } out_t;

  typedef struct {
    int   edge_k;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rn = 1'b0;
  logic rn_full = 1'b0;

  logic        cke_nom, cke_min, cke_full;
  logic [3:0]  cmd_nom, cmd_min, cmd_full;
  logic [1:0]  ba_nom, ba_min, ba_full;
  logic [12:0] a_nom, a_min, a_full;
  logic        done_nom, done_min, done_full;
  out_t        o_nom, o_min, o_full;

  assign o_nom  = {cke_nom, cmd_nom, ba_nom, a_nom, done_nom};
  assign o_min  = {cke_min, cmd_min, ba_min, a_min, done_min};
  assign o_full = {cke_full, cmd_full, ba_full, a_full, done_full};

  sdram_init_seq #(
    .CLK_FREQ_HZ(1_000_000), .T_POWERUP_US(10), .T_RP(2), .T_RFC(7),
    .T_MRD(2), .REFRESH_COUNT(2), .MODE_REG(13'h030)
  ) dut_nom (
    .clk(clk), .reset_n(rn), .cke(cke_nom), .cmd(cmd_nom),
    .ba(ba_nom), .a(a_nom), .done(done_nom)
  );

  sdram_init_seq #(
    .CLK_FREQ_HZ(1_000_000), .T_POWERUP_US(10), .T_RP(1), .T_RFC(1),
    .T_MRD(1), .REFRESH_COUNT(1), .MODE_REG(13'h030)
  ) dut_min (
    .clk(clk), .reset_n(rn), .cke(cke_min), .cmd(cmd_min),
    .ba(ba_min), .a(a_min), .done(done_min)
  );

  sdram_init_seq dut_full (
    .clk(clk), .reset_n(rn_full), .cke(cke_full), .cmd(cmd_full),
    .ba(ba_full), .a(a_full), .done(done_full)
  );

  // Edge index since reset release; -1 while in reset.
  int k_nom = -1;
  int k_full = -1;
  always @(posedge clk or negedge rn)      if (!rn) k_nom <= -1; else k_nom <= k_nom + 1;
  always @(posedge clk or negedge rn_full) if (!rn_full) k_full <= -1; else k_full <= k_full + 1;

  int   checks = 0;
  int   passes = 0;
  out_t cap [0:63];
  out_t rst_v;

  // Expected pins after edge k, built from the command schedule implied by the timing rules.
  function automatic out_t model(input int p, input int trp, input int trfc,
                                 input int tmrd, input int nref, input int k);
    out_t o;
    int   pre_e, mrs_e, done_e;
    o.cke = 1'b0; o.cmd = C_NOP; o.ba = 2'd0; o.a = 13'd0; o.done = 1'b0;
    pre_e  = p + 1;
    mrs_e  = pre_e + trp + nref * trfc;
    done_e = mrs_e + tmrd;
    if (k < 0) return o;
    o.cke  = (k >= p);
    o.done = (k >= done_e);
    if (k == pre_e) begin
      o.cmd = C_PRE;
      o.a   = 13'h400;
    end
    for (int i = 0; i < nref; i++) begin
      if (k == pre_e + trp + i * trfc) o.cmd = C_REF;
    end
    if (k == mrs_e) begin
      o.cmd = C_MRS;
      o.a   = 13'h030;
    end
    return o;
  endfunction

  task automatic cmp(input string name, input int k, input out_t act, input out_t exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s edge %0d: got cke=%b cmd=%b ba=%0d a=%h done=%b, want cke=%b cmd=%b ba=%0d a=%h done=%b",
               name, k, act.cke, act.cmd, act.ba, act.a, act.done,
               exp.cke, exp.cmd, exp.ba, exp.a, exp.done);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp("nominal", k_nom, o_nom, model(10, 2, 7, 2, 2, k_nom));
      cmp("min_spacing", k_nom, o_min, model(10, 1, 1, 1, 1, k_nom));
      cmp("full_size", k_full, o_full, model(20000, 2, 7, 2, 8, k_full));
      if (k_nom >= 0 && k_nom < 64) cap[k_nom] = o_nom;
    end
  endtask

  vec_t tbl [10];

  initial begin
    int g;
    rst_v = {1'b0, C_NOP, 2'b00, 13'h0000, 1'b0};
    tbl[0] = '{9,  {1'b0, C_NOP, 2'b00, 13'h000, 1'b0}};
    tbl[1] = '{10, {1'b1, C_NOP, 2'b00, 13'h000, 1'b0}};
    tbl[2] = '{11, {1'b1, C_PRE, 2'b00, 13'h400, 1'b0}};
    tbl[3] = '{12, {1'b1, C_NOP, 2'b00, 13'h000, 1'b0}};
    tbl[4] = '{13, {1'b1, C_REF, 2'b00, 13'h000, 1'b0}};
    tbl[5] = '{19, {1'b1, C_NOP, 2'b00, 13'h000, 1'b0}};
    tbl[6] = '{20, {1'b1, C_REF, 2'b00, 13'h000, 1'b0}};
    tbl[7] = '{27, {1'b1, C_MRS, 2'b00, 13'h030, 1'b0}};
    tbl[8] = '{28, {1'b1, C_NOP, 2'b00, 13'h000, 1'b0}};
    tbl[9] = '{29, {1'b1, C_NOP, 2'b00, 13'h000, 1'b1}};

    step(5);
    $display("reset hold: 5 cycles with reset_n low");
    rn = 1'b1;
    rn_full = 1'b1;

    g = 0;
    while (k_nom != 15 && g < 100) begin
      step(1);
      g++;
    end
    checks++;
    if (k_nom == 15) passes++;
    else $display("FAIL reach_edge15: got edge %0d, want 15", k_nom);

    // Asynchronous reset between edges 15 and 16; outputs must clear without a clock edge.
    #2 rn = 1'b0;
    #1;
    cmp("async_reset_nom", -1, o_nom, rst_v);
    cmp("async_reset_min", -1, o_min, rst_v);
    $display("mid-sequence reset asserted at t=%0t", $time);
    step(2);
    rn = 1'b1;

    step(45);
    foreach (tbl[i]) begin
      cmp("table", tbl[i].edge_k, cap[tbl[i].edge_k], tbl[i].exp);
      $display("vector edge %0d: cmd=%b a=%h cke=%b done=%b", tbl[i].edge_k,
               cap[tbl[i].edge_k].cmd, cap[tbl[i].edge_k].a,
               cap[tbl[i].edge_k].cke, cap[tbl[i].edge_k].done);
    end

    for (int t = 0; t < 8; t++) begin
      int run_n, hold_n, off;
      run_n  = $urandom_range(1, 40);
      hold_n = $urandom_range(1, 3);
      off    = $urandom_range(1, 3);
      step(run_n);
      #(off) rn = 1'b0;
      #1;
      cmp("rand_async_reset", -1, o_nom, rst_v);
      step(hold_n);
      rn = 1'b1;
      $display("trial %0d: reset after %0d edges, held %0d cycles", t, run_n, hold_n);
    end

    g = 0;
    while (k_full < 20161 && g < 25000) begin
      step(1);
      g++;
    end
    checks++;
    if (k_full >= 20161) passes++;
    else $display("FAIL full_run_budget: got edge %0d, want 20161", k_full);
    $display("full-size run reached edge %0d, done=%b", k_full, done_full);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
